// File: rtl/program_loader_pkg.sv
// Shared constants, state codes and the memory-write record for the boot loader.
package program_loader_pkg;

  localparam int DEF_MAX_WORDS   = 16;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_LEN_W       = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;

  // One instruction-memory write as presented to the CPU init port.
  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
  } init_wr_t;

  function automatic logic len_legal(input int unsigned l, input int unsigned max_w);
    return (l != 0) && (l <= max_w);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host word stream (valid/ready) feeding the loader.
interface program_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader_hold_timer.sv
// Loadable down-counter; tc is high once the count has reached zero.
module hold_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: streams a program into CPU instruction memory, holds the CPU
// in reset for a fixed interval, then releases it to run from address 0.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MAX_WORDS   = DEF_MAX_WORDS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int LEN_W       = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  program_loader_if.slave  host,
  output logic             initialize,
  output logic [31:0]      instruction_initialize_data,
  output logic [31:0]      instruction_initialize_address,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_loaded
);

  localparam int HT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [2:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wl;
  logic [LEN_W-1:0] wl_next;
  init_wr_t         wr_q;
  logic             hs;
  logic             start_ok;
  logic             hold_tc;

  assign host.in_ready = (state == ST_LOAD);
  assign busy          = (state == ST_LOAD) || (state == ST_FLUSH) || (state == ST_HOLD);
  assign hs            = host.in_valid && host.in_ready;
  assign start_ok      = len_legal(32'(len), MAX_WORDS);
  assign wl_next       = wl + LEN_W'(1);

  // Timer is armed during FLUSH so HOLD lasts exactly HOLD_CYCLES cycles.
  hold_timer #(.W(HT_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_FLUSH),
    .load_val (HT_W'(HOLD_CYCLES - 1)),
    .en       (state == ST_HOLD),
    .tc       (hold_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cpu_rst <= 1'b1;
      wr_q    <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
      wl      <= '0;
      len_q   <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN: begin
          if (start) begin
            if (start_ok) begin
              len_q   <= len;
              wl      <= '0;
              cpu_rst <= 1'b1;
              state   <= ST_LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // Without a handshake the last write is simply repeated, which is harmless.
          if (hs) begin
            wr_q  <= '{en: 1'b1, addr: 32'(wl) << 2, data: host.in_data};
            wl    <= wl_next;
            if (wl_next == len_q) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          wr_q.en <= 1'b0;
          state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_tc) begin
            state   <= ST_RUN;
            cpu_rst <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign initialize                     = wr_q.en;
  assign instruction_initialize_data    = wr_q.data;
  assign instruction_initialize_address = wr_q.addr;
  assign words_loaded                   = wl;

  a_flush_single: assert property (@(posedge clk) disable iff (!rst)
    state == ST_FLUSH |=> state == ST_HOLD);
  a_wl_bound: assert property (@(posedge clk) disable iff (!rst)
    wl <= len_q);
  a_init_window: assert property (@(posedge clk) disable iff (!rst)
    initialize |-> (state == ST_LOAD || state == ST_FLUSH));

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: expected memory writes are
// queued at start time and checked by a monitor as the DUT presents them.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int MAXW = 16;
  localparam int HOLD = 4;
  localparam int LW   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          initialize;
  logic [31:0]   idata, iaddr;
  logic          cpu_rst, busy, done, error;
  logic [LW-1:0] words_loaded;

  program_loader_if hif();

  program_loader #(.MAX_WORDS(MAXW), .HOLD_CYCLES(HOLD), .LEN_W(LW)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .len                            (len),
    .host                           (hif),
    .initialize                     (initialize),
    .instruction_initialize_data    (idata),
    .instruction_initialize_address (iaddr),
    .cpu_rst                        (cpu_rst),
    .busy                           (busy),
    .done                           (done),
    .error                          (error),
    .words_loaded                   (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  wr_t         exp_q[$];
  logic [31:0] host_q[$];
  logic [31:0] prog[$];
  bit          vpat_q[$];
  logic [31:0] ref_mem[MAXW];
  logic [31:0] obs_mem[MAXW];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          done_seen = 0;
  bit          host_en = 0;
  int          valid_pct = 100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_start(input int l);
    @(posedge clk); #1;
    start = 1'b1; len = LW'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill_prog(input int l);
    prog.delete();
    for (int k = 0; k < l; k++) prog.push_back($urandom);
  endtask

  // Model: word k of a legal load lands at byte address 4*k, in order.
  task automatic begin_load();
    wr_t e;
    foreach (prog[k]) begin
      e.addr = 32'(k) << 2;
      e.data = prog[k];
      exp_q.push_back(e);
      ref_mem[k] = prog[k];
      host_q.push_back(prog[k]);
    end
    done_seen = 0;
    do_start(prog.size());
    host_en = 1;
  endtask

  task automatic finish_load(input int l);
    int bad;
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      @(negedge clk); #1;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    @(negedge clk);
    chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("done_single", 32'(done), 32'd0);
    chk("words_loaded", 32'(words_loaded), 32'(l));
    chk("busy_run", 32'(busy), 32'd0);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    chk("host_drained", 32'(host_q.size()), 32'd0);
    bad = 0;
    for (int k = 0; k < MAXW; k++) if (obs_mem[k] !== ref_mem[k]) bad++;
    chk("mem_image", 32'(bad), 32'd0);
    host_en = 0;
    exp_q.delete();
    host_q.delete();
  endtask

  task automatic illegal_start(input int l, input logic exp_cpu_rst);
    do_start(l);
    @(negedge clk);
    chk("err_pulse", 32'(error), 32'd1);
    chk("err_cpu_rst", 32'(cpu_rst), 32'(exp_cpu_rst));
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_ready", 32'(hif.in_ready), 32'd0);
    @(negedge clk);
    chk("err_clear", 32'(error), 32'd0);
  endtask

  initial begin
    int l;
    hif.in_valid = 1'b0;
    hif.in_data  = '0;
    for (int k = 0; k < MAXW; k++) begin ref_mem[k] = '0; obs_mem[k] = '0; end

    fork
      // Host: offers host_q[0] with random or patterned valid while enabled.
      begin
        bit take, v;
        forever begin
          @(negedge clk);
          take = hif.in_valid && hif.in_ready;
          @(posedge clk); #2;
          if (take && host_q.size() > 0) void'(host_q.pop_front());
          if (host_en && host_q.size() > 0) begin
            if (vpat_q.size() > 0) v = vpat_q.pop_front();
            else v = ($urandom_range(1, 100) <= valid_pct);
            hif.in_valid = v;
            hif.in_data  = host_q[0];
          end else begin
            hif.in_valid = 1'b0;
          end
        end
      end
      // Memory image: a presented write lands at the following rising edge.
      begin
        bit pend;
        logic [31:0] pa, pd;
        forever begin
          @(negedge clk);
          pend = initialize; pa = iaddr; pd = idata;
          @(posedge clk);
          if (rst && pend && (pa >> 2) < MAXW) obs_mem[pa >> 2] = pd;
        end
      end
      // Monitor: scoreboard pops on each new write, plus sequencing timing.
      begin
        int ncyc = 0, rdy_fall = 0, init_fall = 0;
        logic p_init = 0, p_rdy = 0, p_cpu_rst = 1, p_done = 0;
        logic [31:0] p_addr = '0, p_data = '0;
        wr_t e;
        forever begin
          @(negedge clk);
          ncyc++;
          if (rst) begin
            if (initialize && (!p_init || iaddr != p_addr || idata != p_data)) begin
              if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL spurious_write: got addr %h data %h expected no write at %0t", iaddr, idata, $time);
              end else begin
                e = exp_q.pop_front();
                chk("wr_addr", iaddr, e.addr);
                chk("wr_data", idata, e.data);
              end
            end
            if (p_rdy && !hif.in_ready) rdy_fall = ncyc;
            if (p_init && !initialize) begin
              chk("flush_len", 32'(ncyc - rdy_fall), 32'd1);
              init_fall = ncyc;
            end
            if (done) begin
              chk("hold_len", 32'(ncyc - init_fall), 32'(HOLD));
              chk("release_edge", 32'({p_cpu_rst, cpu_rst}), 32'b10);
              chk("done_pulse", 32'(p_done), 32'd0);
              done_seen = 1;
            end
          end
          p_init = initialize; p_rdy = hif.in_ready; p_cpu_rst = cpu_rst;
          p_done = done; p_addr = iaddr; p_data = idata;
        end
      end
    join_none

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_init", 32'(initialize), 32'd0);
    chk("rst_ready", 32'(hif.in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("idle_init", 32'(initialize), 32'd0);
    chk("idle_addr", iaddr, 32'd0);
    chk("idle_data", idata, 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_error", 32'(error), 32'd0);
    chk("idle_wl", 32'(words_loaded), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed three-word program, host always valid.
    prog = '{32'h20010005, 32'h20020003, 32'h00221820};
    valid_pct = 100;
    begin_load();
    finish_load(3);

    // Throttled host on a reprogram from RUN.
    fill_prog(2);
    vpat_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    begin_load();
    finish_load(2);

    // Illegal lengths while the CPU runs: CPU must stay released.
    illegal_start(0, 1'b0);
    illegal_start(17, 1'b0);
    illegal_start(31, 1'b0);

    // Reprogram a single word.
    prog = '{32'h20010007};
    begin_load();
    @(negedge clk);
    chk("reprog_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reprog_busy", 32'(busy), 32'd1);
    finish_load(1);

    // Asynchronous reset after two of four words.
    fill_prog(4);
    begin_load();
    for (int i = 0; i < 100 && exp_q.size() > 2; i++) begin
      @(negedge clk); #1;
    end
    chk("midload_reach", 32'(exp_q.size()), 32'd2);
    rst = 1'b0;
    #1;
    chk("arst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("arst_init", 32'(initialize), 32'd0);
    chk("arst_ready", 32'(hif.in_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    host_en = 0;
    exp_q.delete();
    host_q.delete();
    @(negedge clk);
    rst = 1'b1;
    illegal_start(0, 1'b1);
    illegal_start(17, 1'b1);
    fill_prog(4);
    begin_load();
    finish_load(4);

    // Randomized loads with stray illegal starts and ignored starts while busy.
    repeat (25) begin
      if ($urandom_range(0, 3) == 0) illegal_start($urandom_range(MAXW + 1, 31), 1'b0);
      l = $urandom_range(1, MAXW);
      fill_prog(l);
      valid_pct = $urandom_range(30, 100);
      begin_load();
      if ($urandom_range(0, 1) == 1) begin
        do_start($urandom_range(0, 31));
        @(negedge clk);
        chk("busy_start_no_err", 32'(error), 32'd0);
        chk("busy_start_busy", 32'(busy), 32'd1);
      end
      finish_load(l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
